// File: rtl/tick_scan_sched.sv
`default_nettype none
// ============================================================================
// Module   : tick_scan_sched
// Brief    : Fast/slow tick-enable scheduler with a one-hot display column scan
//            and a runtime-reprogrammable fast divisor.
// Revision : 1.0 - initial release
// ============================================================================
module tick_scan_sched #(
    parameter int FAST_DIV   = 261780,
    parameter int SLOW_RATIO = 32,
    parameter int NUM_COLS   = 5,
    parameter int CNT_W      = 20
) (
    input  logic                        clk50Mhz,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        cfg_valid,
    input  logic [CNT_W-1:0]            cfg_div,
    output logic                        cfg_ready,
    output logic                        tick_fast,
    output logic                        tick_slow,
    output logic [$clog2(NUM_COLS)-1:0] col_idx,
    output logic [NUM_COLS-1:0]         col_sel,
    output logic                        frame_start
);

    localparam int c_col_w  = $clog2(NUM_COLS);
    localparam int c_slow_w = (SLOW_RATIO > 1) ? $clog2(SLOW_RATIO) : 1;

    localparam logic [c_slow_w-1:0] c_slow_last = c_slow_w'(SLOW_RATIO - 1);
    localparam logic [c_col_w-1:0]  c_col_last  = c_col_w'(NUM_COLS - 1);
    localparam logic [CNT_W-1:0]    c_min_div   = CNT_W'(2);

    // SETTLE keeps cfg_ready low for one extra cycle after the divisor commit
    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_pend   = 2'd1;
    localparam logic [1:0] c_settle = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [CNT_W-1:0]    r_presc;
    logic [CNT_W-1:0]    r_div;
    logic [CNT_W-1:0]    r_pend;
    logic [c_slow_w-1:0] r_slow;
    logic [c_col_w-1:0]  r_col_idx;
    logic [NUM_COLS-1:0] r_col_sel;
    logic                r_tick_fast;
    logic                r_tick_slow;
    logic                r_frame_start;
    logic                r_cfg_ready;
    logic                w_wrap;
    logic [CNT_W-1:0]    w_cfg_clamped;

    assign w_wrap        = enable && (r_presc == (r_div - CNT_W'(1)));
    assign w_cfg_clamped = (cfg_div < c_min_div) ? c_min_div : cfg_div;

    always_ff @(posedge clk50Mhz) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:   if (cfg_valid) w_state_nxt = c_pend;
            c_pend:   if (w_wrap)    w_state_nxt = c_settle;
            c_settle: w_state_nxt = c_idle;
            default:  w_state_nxt = c_idle;
        endcase
    end

    always_ff @(posedge clk50Mhz) begin
        if (reset) begin
            r_presc       <= '0;
            r_div         <= CNT_W'(FAST_DIV);
            r_pend        <= '0;
            r_slow        <= '0;
            r_col_idx     <= '0;
            r_col_sel     <= NUM_COLS'(1);
            r_tick_fast   <= 1'b0;
            r_tick_slow   <= 1'b0;
            r_frame_start <= 1'b0;
            r_cfg_ready   <= 1'b1;
        end else begin
            r_tick_fast   <= w_wrap;
            r_tick_slow   <= w_wrap && (r_slow == c_slow_last);
            r_frame_start <= w_wrap && (r_col_idx == c_col_last);
            r_cfg_ready   <= (w_state_nxt == c_idle);

            if (w_wrap) begin
                r_presc   <= '0;
                r_slow    <= (r_slow == c_slow_last) ? '0 : r_slow + c_slow_w'(1);
                r_col_idx <= (r_col_idx == c_col_last) ? '0 : r_col_idx + c_col_w'(1);
                r_col_sel <= {r_col_sel[NUM_COLS-2:0], r_col_sel[NUM_COLS-1]};
            end else if (enable) begin
                r_presc <= r_presc + CNT_W'(1);
            end

            if ((r_state == c_idle) && cfg_valid) begin
                r_pend <= w_cfg_clamped;
            end
            // Committing on the wrap itself makes the new period start with the next count
            if ((r_state == c_pend) && w_wrap) begin
                r_div <= r_pend;
            end
        end
    end

    assign cfg_ready   = r_cfg_ready;
    assign tick_fast   = r_tick_fast;
    assign tick_slow   = r_tick_slow;
    assign col_idx     = r_col_idx;
    assign col_sel     = r_col_sel;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_tick_scan_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_scan_sched
// Brief    : Directed self-checking bench for tick_scan_sched (DIV=4, RATIO=3, COLS=5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tick_scan_sched;

    localparam int c_cnt_w = 20;

    logic               clk50Mhz = 1'b0;
    logic               reset    = 1'b1;
    logic               enable   = 1'b1;
    logic               cfg_valid = 1'b0;
    logic [c_cnt_w-1:0] cfg_div  = '0;
    logic               cfg_ready;
    logic               tick_fast;
    logic               tick_slow;
    logic [2:0]         col_idx;
    logic [4:0]         col_sel;
    logic               frame_start;

    int n_checks = 0;
    int n_fail   = 0;

    tick_scan_sched #(
        .FAST_DIV   (4),
        .SLOW_RATIO (3),
        .NUM_COLS   (5),
        .CNT_W      (c_cnt_w)
    ) u_dut (
        .clk50Mhz    (clk50Mhz),
        .reset       (reset),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_div     (cfg_div),
        .cfg_ready   (cfg_ready),
        .tick_fast   (tick_fast),
        .tick_slow   (tick_slow),
        .col_idx     (col_idx),
        .col_sel     (col_sel),
        .frame_start (frame_start)
    );

    always #5 clk50Mhz = ~clk50Mhz;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk50Mhz);
        #1;
    endtask

    task automatic reset_dut();
        reset     = 1'b1;
        enable    = 1'b1;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tf"},    32'(tick_fast),   32'd0);
        check({tag, "_ts"},    32'(tick_slow),   32'd0);
        check({tag, "_fs"},    32'(frame_start), 32'd0);
        check({tag, "_col"},   32'(col_idx),     32'd0);
        check({tag, "_sel"},   32'(col_sel),     32'd1);
        check({tag, "_ready"}, 32'(cfg_ready),   32'd1);
    endtask

    task automatic run_clamp(input logic [c_cnt_w-1:0] d);
        reset_dut();
        for (int n = 1; n <= 11; n++) begin
            cfg_valid = (n == 1);
            cfg_div   = d;
            step();
            // old period gives the wrap at 4, then the clamped period of 2
            check($sformatf("clamp%0d_tf@%0d", d, n), 32'(tick_fast),
                  32'((n == 4) || (n == 6) || (n == 8) || (n == 10)));
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset and free run
        reset_dut();
        check_reset_vals("rst");
        for (int n = 1; n <= 24; n++) begin
            step();
            check($sformatf("run_tf@%0d", n),  32'(tick_fast),   32'(n % 4 == 0));
            check($sformatf("run_ts@%0d", n),  32'(tick_slow),   32'((n == 12) || (n == 24)));
            check($sformatf("run_fs@%0d", n),  32'(frame_start), 32'(n == 20));
            check($sformatf("run_col@%0d", n), 32'(col_idx),     32'((n / 4) % 5));
            check($sformatf("run_sel@%0d", n), 32'(col_sel),     32'(1) << ((n / 4) % 5));
        end

        // reconfiguration to a period of 6, with an ignored second offer
        reset_dut();
        for (int n = 1; n <= 21; n++) begin
            cfg_valid = (n >= 5) && (n <= 8);
            cfg_div   = (n == 5) ? 20'd6 : 20'd3;
            step();
            check($sformatf("cfg_tf@%0d", n),    32'(tick_fast),
                  32'((n == 4) || (n == 8) || (n == 14) || (n == 20)));
            check($sformatf("cfg_ready@%0d", n), 32'(cfg_ready), 32'((n < 5) || (n >= 9)));
        end
        cfg_valid = 1'b0;

        // divisor clamping
        run_clamp(20'd0);
        run_clamp(20'd1);

        // enable gap at edges 2..4
        reset_dut();
        for (int n = 1; n <= 11; n++) begin
            enable = !((n >= 2) && (n <= 4));
            step();
            check($sformatf("gap_tf@%0d", n),  32'(tick_fast),   32'((n == 7) || (n == 11)));
            check($sformatf("gap_ts@%0d", n),  32'(tick_slow),   32'd0);
            check($sformatf("gap_fs@%0d", n),  32'(frame_start), 32'd0);
            check($sformatf("gap_col@%0d", n), 32'(col_idx),     32'((n >= 11) ? 2 : (n >= 7) ? 1 : 0));
        end
        enable = 1'b1;

        // reset while a divisor of 9 is pending
        reset_dut();
        for (int n = 1; n <= 5; n++) begin
            cfg_valid = (n == 5);
            cfg_div   = 20'd9;
            step();
        end
        cfg_valid = 1'b0;
        check("mid_pending_ready", 32'(cfg_ready), 32'd0);
        check("mid_pre_col",       32'(col_idx),   32'd1);
        reset = 1'b1;
        step();
        check_reset_vals("mid");
        reset = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            step();
            check($sformatf("mid_tf@%0d", n),    32'(tick_fast), 32'(n % 4 == 0));
            check($sformatf("mid_ready@%0d", n), 32'(cfg_ready), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
